// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encodings and parity helper.
// Used by both the transmitter and the receiver so their framing stays in lockstep.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    function automatic logic uart_parity(input logic [7:0] data, input logic mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last clk of every CLKS_PER_BIT-cycle period.
// Latency: period restarts on the edge after clear; no backpressure (free-running while clear is low).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign bit_tick = !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits, optional parity, 1-2 stop bits; tx_out registered.
// Latency: line drops on the handshake edge; tx_ready only in IDLE, so tx_valid while busy stalls.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [3:0] LAST_DATA = 4'(UART_DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        par_q, par_d;
    logic        tx_out_q, tx_out_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_tick;
    logic        cur_bit;
    logic [7:0]  shifted;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .bit_tick(bit_tick)
    );

    assign cur_bit = (MSB_FIRST != 0) ? shift_q[7] : shift_q[0];
    assign shifted = (MSB_FIRST != 0) ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tx_out_d  = tx_out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b1;
                tx_out_d = UART_IDLE_LEVEL;
                if (tx_valid && ready_q) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    par_d     = uart_parity(tx_data, PAR_MODE);
                    tx_out_d  = 1'b0;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    tx_out_d  = cur_bit;
                    shift_d   = shifted;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d  = ST_PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d  = ST_STOP;
                            tx_out_d = UART_IDLE_LEVEL;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_out_d  = cur_bit;
                        shift_d   = shifted;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d  = ST_STOP;
                    tx_out_d = UART_IDLE_LEVEL;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // Ready is raised here so a held tx_valid hands off in the first IDLE cycle.
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_out_d = UART_IDLE_LEVEL;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_out_q  <= UART_IDLE_LEVEL;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_out_q  <= tx_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances cover parity/stop/bit-order variants at 4 clks per bit.
// Expected frames come from a stimulus table and a bench-side framing model via a scoreboard queue.
module tb_uart_tx;

    localparam int C  = 4;
    localparam int NB = 11;
    localparam int FC = NB * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid [4];
    logic [7:0] tx_data  [4];
    logic       tx_ready [4];
    logic       tx_out   [4];
    logic       tx_busy  [4];
    logic       tx_done  [4];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C)) u0 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1)) u1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
        .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.CLKS_PER_BIT(C), .MSB_FIRST(0)) u3 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[3]), .tx_data(tx_data[3]),
        .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    typedef struct {
        int          idx;
        logic [7:0]  dat;
        logic [10:0] frame;   // first line bit in [10]
    } vec_t;

    vec_t        vecs [10];
    logic [10:0] exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Framing model from the instance's configuration, independent of the DUT's shifting scheme.
    function automatic logic [10:0] model_frame(input int idx, input logic [7:0] b);
        logic [10:0] r;
        int          p;
        bit          pe, po, msb;
        int          sb;
        pe  = (idx != 2);
        po  = (idx == 1);
        msb = (idx != 3);
        sb  = (idx == 2) ? 2 : 1;
        r   = '0;
        p   = 10;
        r[p] = 1'b0; p--;
        for (int i = 0; i < 8; i++) begin
            r[p] = msb ? b[7-i] : b[i];
            p--;
        end
        if (pe) begin
            r[p] = po ? ~^b : ^b;
            p--;
        end
        for (int s = 0; s < sb; s++) begin
            r[p] = 1'b1;
            p--;
        end
        return r;
    endfunction

    // Entered and left at a negedge; leaves the bench in the cycle where tx_done is high.
    task automatic run_frame(input int idx, input logic [7:0] b, input bit keep,
                             input logic [7:0] nb, input logic [10:0] fr, output int waited);
        logic [10:0] e;
        waited = 0;
        tx_valid[idx] = 1'b1;
        tx_data[idx]  = b;
        while (!tx_ready[idx] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            chk($sformatf("ready_timeout_u%0d", idx), 32'd0, 32'd1);
            tx_valid[idx] = 1'b0;
            return;
        end
        exp_q.push_back(fr);
        @(posedge clk);
        @(negedge clk);
        if (keep) tx_data[idx] = nb;
        else      tx_valid[idx] = 1'b0;
        e = exp_q.pop_front();
        for (int k = 0; k < FC; k++) begin
            chk($sformatf("line_u%0d_%02h_cyc%0d", idx, b, k), 32'(tx_out[idx]), 32'(e[10 - k/C]));
            chk($sformatf("flags_u%0d_%02h_cyc%0d", idx, b, k),
                {29'd0, tx_busy[idx], tx_ready[idx], tx_done[idx]}, 32'b100);
            @(negedge clk);
        end
        chk($sformatf("frame_end_u%0d_%02h", idx, b),
            {28'd0, tx_out[idx], tx_busy[idx], tx_ready[idx], tx_done[idx]}, 32'b1011);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          w;
        logic [7:0]  rb;

        vecs[0] = '{0, 8'hA5, 11'b0_10100101_0_1};
        vecs[1] = '{0, 8'h00, 11'b0_00000000_0_1};
        vecs[2] = '{0, 8'hFF, 11'b0_11111111_0_1};
        vecs[3] = '{0, 8'h80, 11'b0_10000000_1_1};
        vecs[4] = '{1, 8'h01, 11'b0_00000001_0_1};
        vecs[5] = '{1, 8'h03, 11'b0_00000011_1_1};
        vecs[6] = '{2, 8'hFF, 11'b0_11111111_11};
        vecs[7] = '{2, 8'h3C, 11'b0_00111100_11};
        vecs[8] = '{3, 8'h80, 11'b0_00000001_1_1};
        vecs[9] = '{3, 8'h0F, 11'b0_11110000_0_1};

        for (int i = 0; i < 4; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        reset = 1'b0;
        tx_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_state_u%0d", i),
                {28'd0, tx_out[i], tx_busy[i], tx_ready[i], tx_done[i]}, 32'b1000);
        end
        reset = 1'b1;
        chk("ready_at_release", 32'(tx_ready[0]), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ready_after_reset_u%0d", i),
                {28'd0, tx_out[i], tx_busy[i], tx_ready[i], tx_done[i]}, 32'b1010);
        end
        tx_valid[0] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].idx, vecs[i].dat, 1'b0, 8'h00, vecs[i].frame, w);
            @(negedge clk);
            chk($sformatf("done_width_vec%0d", i), 32'(tx_done[vecs[i].idx]), 32'd0);
        end

        // Held tx_valid: second byte presented mid-frame must not leak into the first frame.
        run_frame(0, 8'h11, 1'b1, 8'h22, model_frame(0, 8'h11), w);
        run_frame(0, 8'h22, 1'b0, 8'h00, model_frame(0, 8'h22), w);
        chk("b2b_first_idle_handshake", 32'(w), 32'd0);
        @(negedge clk);
        chk("b2b_done_width", 32'(tx_done[0]), 32'd0);

        // Reset ten cycles into a frame whose third bit (d6 of 0x80) holds the line low.
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h80;
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_line_low", 32'(tx_out[0]), 32'd0);
        #2 reset = 1'b0;
        tx_valid[0] = 1'b1;
        #1;
        chk("async_reset_line",
            {28'd0, tx_out[0], tx_busy[0], tx_ready[0], tx_done[0]}, 32'b1000);
        repeat (3) begin
            @(negedge clk);
            chk("in_reset_flags",
                {28'd0, tx_out[0], tx_busy[0], tx_ready[0], tx_done[0]}, 32'b1000);
        end
        reset = 1'b1;
        chk("ready_low_at_release", 32'(tx_ready[0]), 32'd0);
        @(negedge clk);
        chk("ready_one_cycle_after_release",
            {28'd0, tx_out[0], tx_busy[0], tx_ready[0], tx_done[0]}, 32'b1010);
        tx_valid[0] = 1'b0;
        @(negedge clk);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 11'b0_10100101_0_1, w);
        @(negedge clk);

        for (int n = 0; n < 64; n++) begin
            rb = 8'($urandom_range(0, 255));
            run_frame(0, rb, 1'b0, 8'h00, model_frame(0, rb), w);
            @(negedge clk);
        end
        for (int n = 0; n < 32; n++) begin
            rb = 8'($urandom_range(0, 255));
            run_frame(3, rb, 1'b0, 8'h00, model_frame(3, rb), w);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter. It is the transmit-side counterpart of the team's uart_rx.
- Accepts one 8-bit byte per valid/ready handshake.
- Serialises it as: start bit (0), 8 data bits, optional parity bit, then 1 or 2 stop bits (1).
- Bit timing comes from an internal baud counter in the clk domain, so no separate bit clock is needed.
- Sits between the register/host interface and the tx pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (legal range 2..65535).
PARITY_EN, 1, 1 = send parity bit after data; 0 = omit it.
PARITY_ODD, 0, 0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data).
STOP_BITS, 1, number of stop bits (1 or 2).
MSB_FIRST, 1, 1 = data bit 7 sent first (matches uart_rx); 0 = bit 0 first.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tx_valid  input  1  host has a byte to send
tx_data  input  8  byte to send; sampled only on handshake
tx_ready  output  1  block can accept a byte (high only in IDLE)
tx_out  output  1  serial line; idle level 1
tx_busy  output  1  high from handshake until frame end
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values (reset low, asynchronous): tx_out=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- tx_ready goes to 1 on the first clk edge after reset deasserts.
- States:
  - IDLE→START on tx_valid&&tx_ready.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→PARITY (if PARITY_EN) or DATA→STOP after 8 bit periods.
  - PARITY→STOP after 1 bit period.
  - STOP→IDLE after STOP_BITS bit periods.
- Handshake: transfer occurs on a clk edge where tx_valid=1 and tx_ready=1.
  - tx_data and the computed parity are latched on that edge.
  - tx_ready drops and tx_busy rises on the same edge.
- Latency: tx_out goes to 0 on the edge that latches the byte. The start bit lasts exactly CLKS_PER_BIT cycles.
- Every bit is held for exactly CLKS_PER_BIT cycles. The baud counter clears on handshake and counts 0..CLKS_PER_BIT-1.
- Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity is computed over the latched byte, never over live tx_data.
- tx_out is driven from a register (glitch-free, no combinational path from inputs).
- Frame end, on the final edge of the last stop bit:
  - state returns to IDLE;
  - tx_done pulses high for exactly 1 cycle;
  - tx_ready=1 and tx_busy=0 from the next cycle.
  - tx_out stays 1.
- Back-to-back: if tx_valid is held, the next handshake happens in the first IDLE cycle. Inter-frame mark time is therefore the stop bit(s) plus exactly 1 clk cycle.
- tx_valid while busy is ignored (no queueing). tx_data changes while busy have no effect.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronously). The frame is truncated, no tx_done is issued, and the byte is discarded.
- tx_valid during reset is not accepted.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index counter is 4 bits. No wrap beyond terminal counts.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1;
  - parity-mode constants (PAR_EVEN, PAR_ODD).
- uart_rx is to be migrated onto the same package.
- One sub-module, uart_baud_gen:
  - ports: clk, reset, clear, bit_tick;
  - parameter: CLKS_PER_BIT;
  - bit_tick pulses on the last cycle of each bit period;
  - reused later by the receiver.

Test Plan:
- CLKS_PER_BIT=4, default parameters; send 8'hA5 → tx_out sequence 0,1,0,1,0,0,1,0,1 (even parity: 4 ones → 0), then 1. Each bit is 4 cycles, 44 cycles total, one tx_done pulse, tx_ready high the following cycle.
- PARITY_ODD=1, send 8'h01 → parity bit 0. Send 8'h03 → parity bit 1. PARITY_EN=0, STOP_BITS=2, send 8'hFF → frame of 0, eight 1s, 1, 1 = 11 bits (44 cycles).
- MSB_FIRST=0, send 8'h80 → data bits on line are 0,0,0,0,0,0,0,1.
- Hold tx_valid high with bytes 8'h11 then 8'h22 → two complete frames separated by exactly 1 idle cycle beyond the stop bit, and two tx_done pulses. Changing tx_data mid-frame does not corrupt the first frame.
- Assert reset at cycle 10 of a frame → tx_out=1 in the same cycle, no tx_done, tx_ready=0 during reset, then 1 one cycle after release. The next frame is transmitted correctly.
- Loopback to uart_rx (shared package, matching CLKS_PER_BIT) with 256 random bytes → all bytes received equal, error never asserted.
